nco_sweep_ctrl: RTL and testbench

Sequencer that configures the NCO frequency tuning word (FTW) for the SFP-Ethernet PLL path. Accepts commands over a valid/ready interface: load a fixed FTW, or step the FTW from start to stop with a programmable dwell per step. Drives the NCO FTW input plus a one-cycle load strobe. Sits between host/register logic and the NCO in the same clk domain.

---
 rtl/nco_ctrl_pkg.sv | 26 ++
 rtl/nco_dwell_timer.sv | 36 +++
 rtl/nco_sweep_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nco_ctrl_pkg.sv
// ============================================================================
// Module : nco_ctrl_pkg
// Brief  : Shared opcode, state and width definitions for the NCO sweep sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nco_ctrl_pkg;

    localparam int FTW_W_DEFAULT   = 32;
    localparam int DWELL_W_DEFAULT = 16;

    // Opcode 3 is reserved and decodes as STOP.
    localparam logic [1:0] OP_STOP  = 2'd0;
    localparam logic [1:0] OP_SET   = 2'd1;
    localparam logic [1:0] OP_SWEEP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_STEP  = 2'd2
    } sweep_state_e;

endpackage

`default_nettype wire

// File: rtl/nco_dwell_timer.sv
// ============================================================================
// Module : nco_dwell_timer
// Brief  : Loadable down-counter; expired is high while the count is zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nco_dwell_timer
    import nco_ctrl_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] value,
    output logic               expired
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
// ============================================================================
// Module : nco_sweep_ctrl
// Brief  : FTW sequencer (SET / SWEEP / STOP) driving an NCO tuning word.
//          Optional NCO_SWEEP_PINGPONG_EN: looping sweeps bounce up/down.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int FTW_W   = FTW_W_DEFAULT,
    parameter int DWELL_W = DWELL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [FTW_W-1:0]   cmd_ftw_start,
    input  logic [FTW_W-1:0]   cmd_ftw_stop,
    input  logic [FTW_W-1:0]   cmd_ftw_step,
    input  logic [DWELL_W-1:0] cmd_dwell,
    input  logic               cmd_loop,
    output logic [FTW_W-1:0]   ftw,
    output logic               ftw_load,
    output logic               busy,
    output logic               done,
    output logic               sweep_dir
);

    sweep_state_e       state_q, state_nx;
    logic [FTW_W-1:0]   start_q, stop_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               loop_q;

    logic [FTW_W-1:0]   ftw_nx;
    logic               load_nx, done_nx;
    logic               accept, capture, tmr_load, tmr_expired;
    logic [DWELL_W-1:0] dwell_sel, tmr_value;
    logic [FTW_W:0]     up_sum;
    logic               up_pass;

`ifdef NCO_SWEEP_PINGPONG_EN
    logic               dir_q, dir_nx;
    logic [FTW_W:0]     dn_diff;
    logic               dn_pass;
`endif

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_ready = (state_q != ST_STEP);
    assign busy      = (state_q != ST_IDLE);

    // Dwell of 0 behaves as 1; the timer is loaded with dwell-1.
    assign dwell_sel = accept ? cmd_dwell : dwell_q;
    assign tmr_value = (dwell_sel == '0) ? '0 : dwell_sel - DWELL_W'(1);

    // One bit wider so a carry out counts as passing the stop bound.
    assign up_sum  = {1'b0, ftw} + {1'b0, step_q};
    assign up_pass = up_sum[FTW_W] || (up_sum[FTW_W-1:0] > stop_q);

`ifdef NCO_SWEEP_PINGPONG_EN
    assign dn_diff = {1'b0, ftw} - {1'b0, step_q};
    assign dn_pass = dn_diff[FTW_W] || (dn_diff[FTW_W-1:0] < start_q);
`endif

    always_comb begin
        state_nx = state_q;
        ftw_nx   = ftw;
        load_nx  = 1'b0;
        done_nx  = 1'b0;
        tmr_load = 1'b0;
        capture  = 1'b0;
`ifdef NCO_SWEEP_PINGPONG_EN
        dir_nx   = dir_q;
`endif
        if (accept) begin
            capture  = 1'b1;
            state_nx = ST_IDLE;
`ifdef NCO_SWEEP_PINGPONG_EN
            dir_nx   = 1'b0;
`endif
            if (cmd_op == OP_SET ||
                (cmd_op == OP_SWEEP &&
                 (cmd_ftw_step == '0 || cmd_ftw_start > cmd_ftw_stop))) begin
                ftw_nx  = cmd_ftw_start;
                load_nx = 1'b1;
                done_nx = 1'b1;
            end else if (cmd_op == OP_SWEEP) begin
                ftw_nx   = cmd_ftw_start;
                load_nx  = 1'b1;
                tmr_load = 1'b1;
                state_nx = ST_DWELL;
            end
        end else begin
            case (state_q)
                ST_DWELL: begin
                    if (tmr_expired) begin
                        state_nx = ST_STEP;
                    end
                end
                ST_STEP: begin
                    load_nx  = 1'b1;
                    tmr_load = 1'b1;
                    state_nx = ST_DWELL;
`ifdef NCO_SWEEP_PINGPONG_EN
                    if (loop_q && dir_q) begin
                        if (!dn_pass) begin
                            ftw_nx = dn_diff[FTW_W-1:0];
                        end else begin
                            dir_nx = 1'b0;
                            ftw_nx = up_pass ? start_q : up_sum[FTW_W-1:0];
                        end
                    end else if (!up_pass) begin
                        ftw_nx = up_sum[FTW_W-1:0];
                    end else if (loop_q) begin
                        // Range narrower than one step falls back to start.
                        dir_nx = 1'b1;
                        ftw_nx = dn_pass ? start_q : dn_diff[FTW_W-1:0];
                    end else begin
                        load_nx  = 1'b0;
                        tmr_load = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end
`else
                    if (!up_pass) begin
                        ftw_nx = up_sum[FTW_W-1:0];
                    end else if (loop_q) begin
                        ftw_nx = start_q;
                    end else begin
                        load_nx  = 1'b0;
                        tmr_load = 1'b0;
                        done_nx  = 1'b1;
                        state_nx = ST_IDLE;
                    end
`endif
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ftw      <= '0;
            ftw_load <= 1'b0;
            done     <= 1'b0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
            loop_q   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            ftw      <= ftw_nx;
            ftw_load <= load_nx;
            done     <= done_nx;
            if (capture) begin
                start_q <= cmd_ftw_start;
                stop_q  <= cmd_ftw_stop;
                step_q  <= cmd_ftw_step;
                dwell_q <= cmd_dwell;
                loop_q  <= cmd_loop;
            end
        end
    end

`ifdef NCO_SWEEP_PINGPONG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_nx;
        end
    end
    assign sweep_dir = dir_q;
`else
    assign sweep_dir = 1'b0;
`endif

    nco_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

endmodule

`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
// ============================================================================
// Module : tb_nco_sweep_ctrl
// Brief  : Directed self-checking bench for nco_sweep_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_ftw_start, cmd_ftw_stop, cmd_ftw_step;
    logic [15:0] cmd_dwell;
    logic        cmd_loop;
    logic [31:0] ftw;
    logic        ftw_load, busy, done, sweep_dir;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nco_sweep_ctrl #(.FTW_W(32), .DWELL_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_ftw_start (cmd_ftw_start),
        .cmd_ftw_stop  (cmd_ftw_stop),
        .cmd_ftw_step  (cmd_ftw_step),
        .cmd_dwell     (cmd_dwell),
        .cmd_loop      (cmd_loop),
        .ftw           (ftw),
        .ftw_load      (ftw_load),
        .busy          (busy),
        .done          (done),
        .sweep_dir     (sweep_dir)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] s, input logic [31:0] p,
                        input logic [31:0] st, input logic [15:0] d, input logic lp);
        cmd_op        = op;
        cmd_ftw_start = s;
        cmd_ftw_stop  = p;
        cmd_ftw_step  = st;
        cmd_dwell     = d;
        cmd_loop      = lp;
        cmd_valid     = 1'b1;
        tick;
        cmd_valid     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int loads, dones;
        logic [31:0] exp_ftw;
        logic [31:0] seq [0:6];
        logic        dseq [0:6];

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_ftw_start = '0;
        cmd_ftw_stop = '0; cmd_ftw_step = '0; cmd_dwell = '0; cmd_loop = 1'b0;
        #12;
        check("rst_ftw",   ftw, 0);
        check("rst_load",  ftw_load, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_dir",   sweep_dir, 0);
        check("rst_ready", cmd_ready, 1);
        tick;
        rst_n = 1'b1;
        tick;

        // SET
        send(2'd1, 32'h1999_999A, 0, 0, 0, 0);
        check("set_ftw",  ftw, 32'h1999_999A);
        check("set_load", ftw_load, 1);
        check("set_done", done, 1);
        check("set_busy", busy, 0);
        tick;
        check("set_load_off", ftw_load, 0);
        check("set_done_off", done, 0);

        // Non-loop sweep 100..130 step 10, dwell 3 -> each value held 4 cycles
        send(2'd2, 100, 130, 10, 3, 0);
        loads = 0; dones = 0;
        for (int k = 0; k < 20; k++) begin
            exp_ftw = (k < 16) ? 32'(100 + 10 * (k / 4)) : 32'd130;
            check("sweep_ftw", ftw, exp_ftw);
            if (k == 0) check("sweep_ready_dwell", cmd_ready, 1);
            if (k == 3) check("sweep_ready_step", cmd_ready, 0);
            if (k == 15) check("sweep_busy", busy, 1);
            loads += int'(ftw_load);
            if (done) begin
                dones++;
                check("sweep_done_at", k, 16);
            end
            tick;
        end
        check("sweep_loads", loads, 4);
        check("sweep_dones", dones, 1);
        check("sweep_idle", busy, 0);

        // Carry past stop must not wrap
        send(2'd2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 0);
        check("wrap_ftw0", ftw, 32'hFFFF_FFF0);
        tick;
        check("wrap_ftw1", ftw, 32'hFFFF_FFF0);
        tick;
        check("wrap_done", done, 1);
        check("wrap_ftw2", ftw, 32'hFFFF_FFF0);
        check("wrap_noload", ftw_load, 0);
        tick;
        check("wrap_idle", busy, 0);

        // Looping sweep 0..20 step 10, dwell 1 -> each value held 2 cycles
`ifdef NCO_SWEEP_PINGPONG_EN
        seq = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20};
        dseq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        seq = '{32'd0, 32'd10, 32'd20, 32'd0, 32'd10, 32'd20, 32'd0};
        dseq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        send(2'd2, 0, 20, 10, 1, 1);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            check("loop_ftw", ftw, seq[k / 2]);
            check("loop_dir", sweep_dir, dseq[k / 2]);
            if ((k % 2) == 0) check("loop_load", ftw_load, 1);
            dones += int'(done);
            tick;
        end
        check("loop_no_done", dones, 0);
        check("loop_at12", ftw, seq[6]);
        send(2'd0, 0, 0, 0, 0, 0);
        check("stop_busy", busy, 0);
        check("stop_ftw", ftw, seq[6]);
        check("stop_load", ftw_load, 0);
        check("stop_done", done, 0);
        tick;
        check("stop_ftw_hold", ftw, seq[6]);
        check("stop_done2", done, 0);

        // Degenerate sweeps behave as SET
        send(2'd2, 55, 100, 0, 4, 1);
        check("step0_ftw", ftw, 55);
        check("step0_done", done, 1);
        check("step0_busy", busy, 0);
        tick;
        send(2'd2, 200, 100, 5, 4, 0);
        check("rev_ftw", ftw, 200);
        check("rev_load", ftw_load, 1);
        check("rev_done", done, 1);
        check("rev_busy", busy, 0);
        tick;

        // Async reset in the middle of a sweep
        send(2'd2, 0, 100, 10, 5, 0);
        tick;
        tick;
        check("mid_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ftw",   ftw, 0);
        check("arst_busy",  busy, 0);
        check("arst_ready", cmd_ready, 1);
        tick;
        rst_n = 1'b1;
        loads = 0;
        for (int k = 0; k < 10; k++) begin
            tick;
            loads += int'(ftw_load);
        end
        check("arst_noload", loads, 0);
        check("arst_ftw_after", ftw, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
